id_pipe_ctrl: RTL and testbench

//  Sequencer for the ID stage. Merges the ID data-hazard stall requests, the cache-busy freezes,
//  the exception flush and the branch-mispredict redirect into IF/ID/EXE write, flush and

---
 rtl/id_pipe_ctrl_pkg.sv | 12 +
 rtl/id_pipe_ctrl_sat.sv | 27 ++
 rtl/id_pipe_ctrl.sv | 140 ++++++++++++++
 tb/tb_id_pipe_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pipe_ctrl_pkg.sv
// Shared ID-stage control definitions: sequencer state encoding and watchdog default.
package id_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DH_STALL = 2'd1,
    WAIT_DS  = 2'd2
  } IdCtrlState_t;

  localparam int MAX_STALL_DEFAULT = 64;

endpackage

// File: rtl/id_pipe_ctrl_sat.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         i_clk,
  input  logic         i_resetn,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/id_pipe_ctrl.sv
// ID-stage sequencer: merges hazard stalls, cache freezes, exception flush and branch
// redirect into IF/ID/EXE pipeline-register controls, plus stall statistics and a hang watchdog.
module id_pipe_ctrl
  import id_pipe_ctrl_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int MAX_STALL = MAX_STALL_DEFAULT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ex_dh_stall,
  input  logic             mem1_dh_stall,
  input  logic             mem2_dh_stall,
  input  logic             icache_busy,
  input  logic             dcache_busy,
  input  logic             exc_flush,
  input  logic             br_mispredict,
  input  logic             id_valid,
  input  logic             if_valid,
  output logic             if_wr,
  output logic             if_flush,
  output logic             id_wr,
  output logic             id_flush,
  output logic             id_diswr,
  output logic             exe_wr,
  output logic             redirect_go,
  output logic [CNT_W-1:0] dh_cycles,
  output logic [CNT_W-1:0] frz_cycles,
  output logic             hang_err,
  output IdCtrlState_t     dbg_state
);

  localparam int RUN_W = $clog2(MAX_STALL + 1);

  IdCtrlState_t r_state, w_next;
  logic         r_hang;
  logic         w_dh, w_frz;
  logic         w_dh_inc, w_frz_inc, w_run_inc, w_run_clr;
  logic [RUN_W-1:0] w_run_cnt;

  assign w_dh  = ex_dh_stall | mem1_dh_stall | mem2_dh_stall;
  assign w_frz = icache_busy | dcache_busy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= RUN;
      r_hang  <= 1'b0;
    end else begin
      r_state <= w_next;
      // Raise on the same edge the run counter lands on MAX_STALL.
      if (w_run_inc && (w_run_cnt >= RUN_W'(MAX_STALL - 1))) begin
        r_hang <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    if_wr       = 1'b1;
    id_wr       = 1'b1;
    exe_wr      = 1'b1;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    id_diswr    = 1'b0;
    redirect_go = 1'b0;
    w_dh_inc    = 1'b0;
    w_frz_inc   = 1'b0;
    w_run_inc   = 1'b0;
    w_run_clr   = 1'b0;
    if (!resetn) begin
      if_wr    = 1'b0;
      id_wr    = 1'b0;
      exe_wr   = 1'b0;
      id_flush = 1'b1;
      id_diswr = 1'b1;
    end else if (exc_flush) begin
      if_flush  = 1'b1;
      id_flush  = 1'b1;
      id_diswr  = 1'b1;
      w_next    = RUN;
      w_run_clr = 1'b1;
    end else if (w_frz) begin
      if_wr     = 1'b0;
      id_wr     = 1'b0;
      exe_wr    = 1'b0;
      w_frz_inc = 1'b1;
    end else begin
      unique case (r_state)
        WAIT_DS: begin
          w_run_clr = 1'b1;
          if (if_valid) begin
            redirect_go = 1'b1;
            w_next      = RUN;
          end else begin
            id_diswr = 1'b1;
          end
        end
        // DH_STALL behaves as RUN with the stall re-evaluated every cycle.
        default: begin
          if (br_mispredict) begin
            w_run_clr = 1'b1;
            if (id_valid) begin
              redirect_go = 1'b1;
              if_flush    = 1'b1;
              w_next      = RUN;
            end else begin
              w_next = WAIT_DS;
            end
          end else if (w_dh) begin
            if_wr     = 1'b0;
            id_wr     = 1'b0;
            id_diswr  = 1'b1;
            w_dh_inc  = 1'b1;
            w_run_inc = 1'b1;
            w_next    = DH_STALL;
          end else begin
            w_run_clr = 1'b1;
            w_next    = RUN;
          end
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_dh_cnt (
    .i_clk(clk), .i_resetn(resetn), .i_inc(w_dh_inc), .i_clr(1'b0), .o_count(dh_cycles)
  );

  sat_counter #(.W(CNT_W)) u_frz_cnt (
    .i_clk(clk), .i_resetn(resetn), .i_inc(w_frz_inc), .i_clr(1'b0), .o_count(frz_cycles)
  );

  sat_counter #(.W(RUN_W), .MAX(RUN_W'(MAX_STALL))) u_run_cnt (
    .i_clk(clk), .i_resetn(resetn), .i_inc(w_run_inc), .i_clr(w_run_clr), .o_count(w_run_cnt)
  );

  assign hang_err  = r_hang;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_id_pipe_ctrl.sv
// Directed bench for id_pipe_ctrl: inputs change on the falling edge, outputs checked 1ns later.
module tb_id_pipe_ctrl;
  import id_pipe_ctrl_pkg::*;

  localparam int CNT_W     = 8;
  localparam int MAX_STALL = 64;

  // Control vector order: {if_wr, id_wr, exe_wr, if_flush, id_flush, id_diswr, redirect_go}
  localparam logic [6:0] C_RESET  = 7'b0000110;
  localparam logic [6:0] C_NORMAL = 7'b1110000;
  localparam logic [6:0] C_STALL  = 7'b0010010;
  localparam logic [6:0] C_WAITDS = 7'b1110010;
  localparam logic [6:0] C_DSGO   = 7'b1110001;
  localparam logic [6:0] C_BRGO   = 7'b1111001;
  localparam logic [6:0] C_EXC    = 7'b1111110;
  localparam logic [6:0] C_FRZ    = 7'b0000000;

  logic clk, resetn;
  logic ex_dh_stall, mem1_dh_stall, mem2_dh_stall, icache_busy, dcache_busy;
  logic exc_flush, br_mispredict, id_valid, if_valid;
  logic if_wr, if_flush, id_wr, id_flush, id_diswr, exe_wr, redirect_go, hang_err;
  logic [CNT_W-1:0] dh_cycles, frz_cycles;
  IdCtrlState_t dbg_state;
  logic [6:0] ctl;

  int checks   = 0;
  int failures = 0;

  assign ctl = {if_wr, id_wr, exe_wr, if_flush, id_flush, id_diswr, redirect_go};

  id_pipe_ctrl #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .resetn(resetn),
    .ex_dh_stall(ex_dh_stall), .mem1_dh_stall(mem1_dh_stall), .mem2_dh_stall(mem2_dh_stall),
    .icache_busy(icache_busy), .dcache_busy(dcache_busy),
    .exc_flush(exc_flush), .br_mispredict(br_mispredict),
    .id_valid(id_valid), .if_valid(if_valid),
    .if_wr(if_wr), .if_flush(if_flush), .id_wr(id_wr), .id_flush(id_flush),
    .id_diswr(id_diswr), .exe_wr(exe_wr), .redirect_go(redirect_go),
    .dh_cycles(dh_cycles), .frz_cycles(frz_cycles), .hang_err(hang_err),
    .dbg_state(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ex_dh_stall = 0; mem1_dh_stall = 0; mem2_dh_stall = 0;
    icache_busy = 0; dcache_busy = 0; exc_flush = 0;
    br_mispredict = 0; id_valid = 0; if_valid = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 1'b0;
    next_cycle(); next_cycle(); #1;
    checks++;
    if (ctl !== C_RESET) begin
      failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RESET);
    end
    checks++;
    if (dbg_state !== RUN || dh_cycles !== 0 || frz_cycles !== 0 || hang_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs got state=%0d dh=%0d frz=%0d hang=%b exp 0/0/0/0",
               dbg_state, dh_cycles, frz_cycles, hang_err);
    end
    next_cycle(); resetn = 1'b1; #1;
    checks++;
    if (ctl !== C_NORMAL) begin
      failures++; $display("FAIL reset_release_ctl got=%b exp=%b", ctl, C_NORMAL);
    end
  endtask

  task automatic test_dh_stall();
    next_cycle(); id_valid = 1; ex_dh_stall = 1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next_cycle();
      #1;
      checks++;
      if (ctl !== C_STALL) begin
        failures++; $display("FAIL dh_stall_ctl cyc=%0d got=%b exp=%b", i, ctl, C_STALL);
      end
    end
    next_cycle(); ex_dh_stall = 0; #1;
    checks++;
    if (ctl !== C_NORMAL || dh_cycles !== 8'd3) begin
      failures++;
      $display("FAIL dh_stall_release got ctl=%b dh=%0d exp ctl=%b dh=3", ctl, dh_cycles, C_NORMAL);
    end
    next_cycle(); #1;
    checks++;
    if (dbg_state !== RUN) begin
      failures++; $display("FAIL dh_stall_state got=%0d exp=%0d", dbg_state, RUN);
    end
  endtask

  task automatic test_mispredict_direct();
    next_cycle(); br_mispredict = 1; id_valid = 1; #1;
    checks++;
    if (ctl !== C_BRGO) begin
      failures++; $display("FAIL br_direct_ctl got=%b exp=%b", ctl, C_BRGO);
    end
    next_cycle(); br_mispredict = 0; #1;
    checks++;
    if (dbg_state !== RUN || ctl !== C_NORMAL) begin
      failures++;
      $display("FAIL br_direct_after got state=%0d ctl=%b exp state=0 ctl=%b", dbg_state, ctl, C_NORMAL);
    end
  endtask

  task automatic test_wait_ds();
    next_cycle(); br_mispredict = 1; id_valid = 0; if_valid = 0; #1;
    checks++;
    if (ctl !== C_NORMAL) begin
      failures++; $display("FAIL wait_ds_enter_ctl got=%b exp=%b", ctl, C_NORMAL);
    end
    next_cycle(); br_mispredict = 0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) next_cycle();
      #1;
      checks++;
      if (dbg_state !== WAIT_DS || ctl !== C_WAITDS) begin
        failures++;
        $display("FAIL wait_ds_hold cyc=%0d got state=%0d ctl=%b exp state=2 ctl=%b",
                 i, dbg_state, ctl, C_WAITDS);
      end
    end
    next_cycle(); if_valid = 1; #1;
    checks++;
    if (ctl !== C_DSGO) begin
      failures++; $display("FAIL wait_ds_go got=%b exp=%b", ctl, C_DSGO);
    end
    next_cycle(); if_valid = 0; id_valid = 1; #1;
    checks++;
    if (dbg_state !== RUN || ctl !== C_NORMAL) begin
      failures++;
      $display("FAIL wait_ds_exit got state=%0d ctl=%b exp state=0 ctl=%b", dbg_state, ctl, C_NORMAL);
    end
  endtask

  task automatic test_exc_priority();
    next_cycle(); exc_flush = 1; icache_busy = 1; mem2_dh_stall = 1; #1;
    checks++;
    if (ctl !== C_EXC) begin
      failures++; $display("FAIL exc_prio_ctl got=%b exp=%b", ctl, C_EXC);
    end
    next_cycle(); exc_flush = 0; icache_busy = 0; mem2_dh_stall = 0; #1;
    checks++;
    if (dbg_state !== RUN || dh_cycles !== 8'd3 || frz_cycles !== 8'd0) begin
      failures++;
      $display("FAIL exc_prio_regs got state=%0d dh=%0d frz=%0d exp 0/3/0", dbg_state, dh_cycles, frz_cycles);
    end
  endtask

  task automatic test_freeze_wait_ds();
    next_cycle(); br_mispredict = 1; id_valid = 0;
    next_cycle(); br_mispredict = 0; dcache_busy = 1; if_valid = 1;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) next_cycle();
      #1;
      checks++;
      if (ctl !== C_FRZ || dbg_state !== WAIT_DS) begin
        failures++;
        $display("FAIL frz_wait_ds cyc=%0d got ctl=%b state=%0d exp ctl=%b state=2",
                 i, ctl, dbg_state, C_FRZ);
      end
    end
    next_cycle(); dcache_busy = 0; #1;
    checks++;
    if (ctl !== C_DSGO) begin
      failures++; $display("FAIL frz_redirect got=%b exp=%b", ctl, C_DSGO);
    end
    next_cycle(); if_valid = 0; #1;
    checks++;
    if (frz_cycles !== 8'd2 || dbg_state !== RUN) begin
      failures++;
      $display("FAIL frz_count got frz=%0d state=%0d exp frz=2 state=0", frz_cycles, dbg_state);
    end
  endtask

  task automatic test_reset_mid_wait_ds();
    next_cycle(); br_mispredict = 1; id_valid = 0;
    next_cycle(); br_mispredict = 0; #1;
    checks++;
    if (dbg_state !== WAIT_DS) begin
      failures++; $display("FAIL rst_mid_setup got=%0d exp=2", dbg_state);
    end
    next_cycle(); resetn = 1'b0; #1;
    checks++;
    if (ctl !== C_RESET || dbg_state !== RUN) begin
      failures++;
      $display("FAIL rst_mid_ctl got ctl=%b state=%0d exp ctl=%b state=0", ctl, dbg_state, C_RESET);
    end
    checks++;
    if (dh_cycles !== 0 || frz_cycles !== 0) begin
      failures++; $display("FAIL rst_mid_cnt got dh=%0d frz=%0d exp 0/0", dh_cycles, frz_cycles);
    end
    next_cycle(); resetn = 1'b1; if_valid = 1; #1;
    checks++;
    if (ctl !== C_NORMAL || dbg_state !== RUN) begin
      failures++;
      $display("FAIL rst_mid_release got ctl=%b state=%0d exp ctl=%b state=0", ctl, dbg_state, C_NORMAL);
    end
    next_cycle(); if_valid = 0;
  endtask

  task automatic test_hang_and_sat();
    next_cycle(); id_valid = 1; ex_dh_stall = 1;
    repeat (63) next_cycle();
    #1;
    checks++;
    if (hang_err !== 1'b0 || dh_cycles !== 8'd63) begin
      failures++; $display("FAIL hang_early got hang=%b dh=%0d exp hang=0 dh=63", hang_err, dh_cycles);
    end
    next_cycle(); #1;
    checks++;
    if (hang_err !== 1'b1 || dh_cycles !== 8'd64) begin
      failures++; $display("FAIL hang_rise got hang=%b dh=%0d exp hang=1 dh=64", hang_err, dh_cycles);
    end
    ex_dh_stall = 0;
    next_cycle(); #1;
    checks++;
    if (hang_err !== 1'b1 || dbg_state !== RUN || ctl !== C_NORMAL) begin
      failures++;
      $display("FAIL hang_sticky got hang=%b state=%0d ctl=%b exp 1/0/%b", hang_err, dbg_state, ctl, C_NORMAL);
    end
    mem1_dh_stall = 1;
    repeat (191) next_cycle();
    #1;
    checks++;
    if (dh_cycles !== 8'hFF) begin
      failures++; $display("FAIL dh_sat_reach got=%0d exp=255", dh_cycles);
    end
    repeat (2) next_cycle();
    #1;
    checks++;
    if (dh_cycles !== 8'hFF || ctl !== C_STALL || hang_err !== 1'b1) begin
      failures++;
      $display("FAIL dh_sat_hold got dh=%0d ctl=%b hang=%b exp dh=255 ctl=%b hang=1",
               dh_cycles, ctl, hang_err, C_STALL);
    end
    mem1_dh_stall = 0;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_dh_stall();
    test_mispredict_direct();
    test_wait_ds();
    test_exc_priority();
    test_freeze_wait_ds();
    test_reset_mid_wait_ds();
    test_hang_and_sat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
